// File: rtl/contador_frequencia_parametrizado.sv
// Parametrised up/down modulo counter stepped by a selectable-rate prescaler tick,
// with a terminal-count pulse and an active-low 7-segment decode of the low nibble.
module contador_frequencia_parametrizado #(
  parameter int unsigned LARGURA = 8,
  parameter int unsigned MODULO  = 256,
  parameter int unsigned DIV0    = 50_000_000,
  parameter int unsigned DIV1    = 25_000_000,
  parameter int unsigned DIV2    = 12_500_000,
  parameter int unsigned DIV3    = 6_250_000
) (
  input  logic               clock_inicial,
  input  logic               reset,
  input  logic               chave_A,
  input  logic               chave_B,
  input  logic               habilita,
  input  logic               sentido,
  output logic               pulso_selecionado,
  output logic [LARGURA-1:0] S,
  output logic               fim_contagem,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               f,
  output logic               g
);

  localparam int unsigned DIV_MAX01 = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int unsigned DIV_MAX23 = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int unsigned DIV_MAX   = (DIV_MAX01 > DIV_MAX23) ? DIV_MAX01 : DIV_MAX23;
  localparam int unsigned PRE_W     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [LARGURA-1:0] S_MAX = LARGURA'(MODULO - 1);

  logic [1:0]         chave;
  logic [1:0]         sel;
  logic [31:0]        div_sel;
  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_fim;
  logic [LARGURA-1:0] s_prox;
  logic               wrap_c;
  logic [6:0]         seg;

  assign chave = {chave_A, chave_B};

  // Divisor chosen by the registered select, so a switch change is seen one edge late.
  always_comb begin
    div_sel = 32'(DIV0);
    case (sel)
      2'b01:   div_sel = 32'(DIV1);
      2'b10:   div_sel = 32'(DIV2);
      2'b11:   div_sel = 32'(DIV3);
      default: div_sel = 32'(DIV0);
    endcase
    pre_fim = PRE_W'(div_sel - 32'd1);
  end

  // Prescaler: a rate change restarts the period and suppresses that cycle's tick.
  always_ff @(posedge clock_inicial) begin
    if (reset) begin
      sel               <= chave;
      pre               <= '0;
      pulso_selecionado <= 1'b0;
    end else if (chave != sel) begin
      sel               <= chave;
      pre               <= '0;
      pulso_selecionado <= 1'b0;
    end else if (pre == pre_fim) begin
      pre               <= '0;
      pulso_selecionado <= 1'b1;
    end else begin
      pre               <= pre + PRE_W'(1);
      pulso_selecionado <= 1'b0;
    end
  end

  // Next count modulo MODULO in the requested direction, flagging a wrap.
  always_comb begin
    s_prox = S;
    wrap_c = 1'b0;
    if (sentido) begin
      if (S == S_MAX) begin
        s_prox = '0;
        wrap_c = 1'b1;
      end else begin
        s_prox = S + LARGURA'(1);
      end
    end else begin
      if (S == '0) begin
        s_prox = S_MAX;
        wrap_c = 1'b1;
      end else begin
        s_prox = S - LARGURA'(1);
      end
    end
  end

  always_ff @(posedge clock_inicial) begin
    if (reset) begin
      S            <= '0;
      fim_contagem <= 1'b0;
    end else if (pulso_selecionado && habilita) begin
      S            <= s_prox;
      fim_contagem <= wrap_c;
    end else begin
      fim_contagem <= 1'b0;
    end
  end

  // Active-low hex glyphs, bit order abcdefg.
  always_comb begin
    seg = 7'b0000001;
    case (S[3:0])
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b0000001;
    endcase
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_contador_frequencia_parametrizado.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_contador_frequencia_parametrizado;

  logic       clk = 1'b0;
  logic       reset, chave_A, chave_B, habilita, sentido;
  logic       pulso, fim;
  logic [3:0] S;
  logic       a, b, c, d, e, f, g;

  contador_frequencia_parametrizado #(
    .LARGURA(4), .MODULO(10), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(1)
  ) dut (
    .clock_inicial(clk), .reset(reset), .chave_A(chave_A), .chave_B(chave_B),
    .habilita(habilita), .sentido(sentido), .pulso_selecionado(pulso), .S(S),
    .fim_contagem(fim), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tid;
    int         cyc;
    logic       p;
    logic [3:0] s;
    logic       fm;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int tid, input int k, input logic p, input int s, input logic fm);
    exp_t x;
    x.tid = tid; x.cyc = k; x.p = p; x.s = 4'(s); x.fm = fm; x.seg = seg_tab[s];
    sb.push_back(x);
  endfunction

  // Monitor: compare every output against the entry queued for this cycle.
  always @(negedge clk) begin
    exp_t x;
    logic [6:0] seg_dut;
    seg_dut = {a, b, c, d, e, f, g};
    while (sb.size() != 0 && sb[0].cyc < cyc) begin
      x = sb.pop_front();
      checks++; errors++;
      $display("FAIL missed_test%0d cyc=%0d got no sample expected one", x.tid, x.cyc);
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      x = sb.pop_front();
      checks++;
      if (pulso !== x.p || S !== x.s || fim !== x.fm || seg_dut !== x.seg) begin
        errors++;
        $display("FAIL test%0d cyc=%0d got pulso=%b S=%0d fim=%b seg=%b expected pulso=%b S=%0d fim=%b seg=%b",
                 x.tid, cyc, pulso, S, fim, seg_dut, x.p, x.s, x.fm, x.seg);
      end
    end
    if (final_req && !final_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      final_done = 1'b1;
    end
  end

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two reset edges, then release; returns the cycle of the last reset edge.
  task automatic do_reset(input logic [1:0] sw, input logic dir, output int c0);
    reset = 1'b1; {chave_A, chave_B} = sw; habilita = 1'b1; sentido = dir;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    int c0;
    int s;
    reset = 1'b1; chave_A = 1'b0; chave_B = 1'b0; habilita = 1'b1; sentido = 1'b1;

    // 1: reset state and DIV0=4 period
    do_reset(2'b00, 1'b1, c0);
    for (int i = 0; i <= 13; i++)
      push(1, c0 + i, (i > 0 && i % 4 == 0), (i >= 1) ? (i - 1) / 4 : 0, 1'b0);
    wait_until(c0 + 13);

    // 2: up wrap at DIV3=1
    do_reset(2'b11, 1'b1, c0);
    for (int i = 0; i <= 12; i++)
      push(2, c0 + i, (i >= 1), (i < 2) ? 0 : (i - 1) % 10, (i == 11));
    wait_until(c0 + 12);

    // 3: down wrap from 0
    do_reset(2'b11, 1'b0, c0);
    for (int i = 0; i <= 4; i++)
      push(3, c0 + i, (i >= 1), (i < 2) ? 0 : 10 - (i - 1), (i == 2));
    wait_until(c0 + 4);

    // 4: rate change 00 -> 01 when pre = 2
    do_reset(2'b00, 1'b1, c0);
    for (int i = 0; i <= 12; i++)
      push(4, c0 + i, (i == 6 || i == 9 || i == 12), (i < 7) ? 0 : ((i < 10) ? 1 : 2), 1'b0);
    wait_until(c0 + 2);
    {chave_A, chave_B} = 2'b01;
    wait_until(c0 + 12);

    // 5: enable held low for 10 edges at S=5, DIV2=2
    do_reset(2'b10, 1'b1, c0);
    for (int i = 0; i <= 23; i++) begin
      s = (i < 3) ? 0 : ((i <= 12) ? (i - 1) / 2 : ((i < 23) ? 5 : 6));
      push(5, c0 + i, (i > 0 && i % 2 == 0), s, 1'b0);
    end
    wait_until(c0 + 11);
    habilita = 1'b0;
    wait_until(c0 + 21);
    habilita = 1'b1;
    wait_until(c0 + 23);

    // 6: reset on the tick cycle with S=9, then first tick at DIV0 after release
    do_reset(2'b11, 1'b1, c0);
    for (int i = 0; i <= 15; i++) begin
      if (i <= 10) push(6, c0 + i, (i >= 1), (i < 2) ? 0 : (i - 1) % 10, 1'b0);
      else         push(6, c0 + i, (i == 15), 0, 1'b0);
    end
    wait_until(c0 + 10);
    reset = 1'b1;
    {chave_A, chave_B} = 2'b00;
    wait_until(c0 + 11);
    reset = 1'b0;
    wait_until(c0 + 15);

    final_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
